spectrum_stream_reader: RTL

//  Frame source for the spectrum-stream interface consumed by the parameter-measure block.

---
 rtl/spectrum_stream_reader_pkg.sv | 14 +
 rtl/spectrum_stream_reader_if.sv | 29 ++
 rtl/spectrum_stream_reader_fifo.sv | 68 ++++++
 rtl/spectrum_stream_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spectrum_stream_reader_pkg.sv
// Shared types and defaults for the spectrum stream reader.
// FSM encodings and default bus widths.
package spectrum_stream_reader_pkg;

  typedef enum logic [1:0] {
    SRD_IDLE  = 2'd0,
    SRD_READ  = 2'd1,
    SRD_DRAIN = 2'd2
  } srd_state_e;

  localparam int SRD_ADDR_W = 13;
  localparam int SRD_DATA_W = 16;

endpackage

// File: rtl/spectrum_stream_reader_if.sv
// Spectrum beat stream: addr/data/valid from the
// reader, ready back from the consumer.
interface spectrum_stream_reader_if
  import spectrum_stream_reader_pkg::*;
#(
  parameter int ADDR_W = SRD_ADDR_W,
  parameter int DATA_W = SRD_DATA_W
);

  logic [DATA_W-1:0] spectrum_data;
  logic [ADDR_W-1:0] spectrum_addr;
  logic              spectrum_valid;
  logic              spectrum_ready;

  modport master (
    output spectrum_data,
    output spectrum_addr,
    output spectrum_valid,
    input  spectrum_ready
  );

  modport slave (
    input  spectrum_data,
    input  spectrum_addr,
    input  spectrum_valid,
    output spectrum_ready
  );

endinterface

// File: rtl/spectrum_stream_reader_fifo.sv
// Small synchronous FIFO with occupancy count
// and a synchronous flush that wins over push/pop.
module stream_sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_q;
  logic [IDX_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] p
  );
    return (p == LAST) ? '0 : p + IDX_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i &&
    ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/spectrum_stream_reader.sv
// Streams magnitude RAM bins 0..SCAN_LEN-1 after each
// FFT frame, credit-limited into an address-tagged FIFO.
module spectrum_stream_reader
  import spectrum_stream_reader_pkg::*;
#(
  parameter int ADDR_W   = SRD_ADDR_W,
  parameter int DATA_W   = SRD_DATA_W,
  parameter int SCAN_LEN = 1024,
  parameter int RAM_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stream_en,
  input  logic              fft_done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  spectrum_stream_reader_if.master spec,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int DEPTH = RAM_LAT + 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int W     = ADDR_W + DATA_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(SCAN_LEN - 1);

  srd_state_e       state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] infl_q;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             abort_q, abort_d;
  logic             fd_q, fd_d;

  logic              pv_q [RAM_LAT];
  logic [ADDR_W-1:0] pa_q [RAM_LAT];

  logic             f_push, f_pop, f_flush;
  logic             f_empty;
  logic [CNT_W-1:0] f_cnt;
  logic [W-1:0]     f_rdata;
  logic [CNT_W:0]   occ;
  logic             credit_ok;
  logic             pipe_v;
  logic             kill;
  logic             fire;
  logic             drain_done;

  assign busy       = (state_q != SRD_IDLE);
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

  assign pipe_v    = pv_q[RAM_LAT-1];
  assign occ       = {1'b0, f_cnt} + {1'b0, infl_q};
  assign credit_ok = occ < (CNT_W + 1)'(DEPTH);
  assign fire      = fft_done && stream_en;
  assign kill      = busy && (!stream_en || abort_q);

  // Returning data of an aborted frame is dropped.
  assign f_flush = kill;
  assign f_push  = pipe_v && !kill;
  assign f_pop   = !f_empty && spec.spectrum_ready;

  assign drain_done = (infl_q == '0) &&
    (((f_cnt == CNT_W'(1)) && f_pop) ||
     (f_cnt == '0));

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    abort_d     = abort_q;
    fd_d        = 1'b0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = rd_ptr_q[ADDR_W-1:0];
    if (kill) begin
      rd_ptr_d = '0;
      pend_d   = 1'b0;
      if (infl_q == CNT_W'(pipe_v)) begin
        state_d = SRD_IDLE;
        abort_d = 1'b0;
      end else begin
        state_d = SRD_DRAIN;
        abort_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        SRD_IDLE: begin
          if (fire) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = '0;
            rd_ptr_d    = PTR_W'(1);
            state_d     = SRD_READ;
          end
        end
        SRD_READ: begin
          if (fire) begin
            if (pend_q) ovr_d = 1'b1;
            else        pend_d = 1'b1;
          end
          if (credit_ok) begin
            ram_rd_en = 1'b1;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            if (rd_ptr_q == LAST)
              state_d = SRD_DRAIN;
          end
        end
        SRD_DRAIN: begin
          if (drain_done) begin
            fd_d = 1'b1;
            // A same-cycle fft_done starts the next frame too.
            if (pend_q || fft_done) begin
              ram_rd_en   = 1'b1;
              ram_rd_addr = '0;
              rd_ptr_d    = PTR_W'(1);
              pend_d      = pend_q && fft_done;
              state_d     = SRD_READ;
            end else begin
              rd_ptr_d = '0;
              state_d  = SRD_IDLE;
            end
          end else if (fire) begin
            if (pend_q) ovr_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
        default: state_d = SRD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SRD_IDLE;
      rd_ptr_q <= '0;
      infl_q   <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      abort_q  <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      infl_q   <= infl_q + CNT_W'(ram_rd_en)
                         - CNT_W'(pipe_v);
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      abort_q  <= abort_d;
      fd_q     <= fd_d;
    end
  end

  // Address tag travels alongside the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= ram_rd_en;
      pa_q[0] <= ram_rd_addr;
      for (int i = 1; i < RAM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  stream_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (f_flush),
    .push_i  (f_push),
    .wdata_i ({pa_q[RAM_LAT-1], ram_rd_data}),
    .pop_i   (f_pop),
    .rdata_o (f_rdata),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  assign spec.spectrum_valid = !f_empty;
  assign spec.spectrum_addr  = f_rdata[W-1:DATA_W];
  assign spec.spectrum_data  = f_rdata[DATA_W-1:0];

endmodule
